mont_mul_cios: RTL and testbench
================================

MONT_MUL_CIOS -- requirements
Module: mont_mul_cios

Interface
REQ-001 Parameter WORDS, default 4: operand width in 32-bit words, with BITS = 32*WORDS; the legal range is 2..16.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  single-cycle request to begin an operation; it SHALL be ignored unless the block is in IDLE.
REQ-005 sqr  input  1  square mode, sampled with start: the B operand equals A and B is not fetched.
REQ-006 n0_inv  input  32  value -N^-1 mod 2^32, sampled with start.
REQ-007 lsu_ren / lsu_wen  output  1 each  LSU read request / LSU write request.
REQ-008 lsu_type  output  2  SHALL be constant DATA_WORD.
REQ-009 lsu_addr_offset  output  32  byte offset of the current word, equal to word_index*4.
REQ-010 lsu_done  input  1  LSU completion of the current access.
REQ-011 lsu_rdata  input  32  read data; lsu_wdata  output  32  write data.
REQ-012 op_address_sel  output  2  base-address select: 0=A, 1=B, 2=N, 3=result.
REQ-013 result  output  BITS  final M value, held until the next start.
REQ-014 done  output  1  one-cycle pulse when the operation completes.

Function
REQ-015 The block SHALL compute M = A*B*R^-1 mod N, with R = 2^BITS and N odd, using word-serial CIOS (Coarsely Integrated Operand Scanning) on a single 32x32+32+32 multiply-accumulate per cycle.
REQ-016 The states SHALL be IDLE, PREPARE, FETCH, MUL_AB, CALC_M, RED, CLEANUP and WRITE.
- IDLE -> PREPARE on start.
- PREPARE: 1 cycle -> FETCH.
REQ-017 FETCH SHALL operate as follows:
- lsu_ren=1 throughout.
- Word order: A[0..W-1], then B[0..W-1] (skipped when sqr=1), then N[0..W-1].
- Each word is latched and the pointer advances on lsu_done.
- After the last N word, with lsu_ren=0 in that cycle, the state goes to MUL_AB.
REQ-018 T SHALL be a (WORDS+2)-word accumulator, cleared in PREPARE.
REQ-019 MUL_AB SHALL process outer index i over WORDS cycles, one per j:
- Each cycle computes (C,S) = T[j] + A[j]*B[i] + C.
- The last cycle also adds C into {T[W+1],T[W]}.
- The state then goes to CALC_M.
REQ-020 CALC_M SHALL take 1 cycle and compute m = (T[0]*n0_inv) mod 2^32, then go to RED.
REQ-021 RED SHALL take WORDS cycles:
- Each cycle computes (C,S) = T[j] + m*N[j] + C.
- S is written to T[j-1] for j>0; S at j=0 is discarded and is always 0.
- The last cycle sets T[W-1] = low(T[W]+C), T[W] = T[W+1] + carry, and T[W+1] = 0.
- Next state: MUL_AB with i+1, or CLEANUP after i = WORDS-1.
REQ-022 The compute latency from MUL_AB entry to CLEANUP entry SHALL be exactly WORDS*(2*WORDS+1) cycles, independent of the data.
REQ-023 CLEANUP SHALL take 1 cycle: a full-width T - N with borrow; if T >= N, including the case T[W] != 0, then T <= T - N. The state then goes to WRITE.
REQ-024 WRITE SHALL operate as follows:
- lsu_wen=1 and op_address_sel=3.
- lsu_wdata = T[k] with offset k*4; k advances on lsu_done.
- After the last word is acknowledged: done=1 for one cycle, lsu_wen=0, state goes to IDLE.
REQ-025 Outside FETCH and WRITE, lsu_ren, lsu_wen, lsu_wdata and lsu_addr_offset SHALL be 0.
REQ-026 A start asserted outside IDLE SHALL have no effect; a start coinciding with done SHALL be ignored.
REQ-027 lsu_done received while neither lsu_ren nor lsu_wen is asserted SHALL be ignored.

Reset
REQ-028 When rst_n=0 at a clock edge, the next state SHALL be as follows, regardless of the current state, including mid-FETCH, mid-RED or mid-WRITE:
- State IDLE.
- All counters 0.
- A, B, N and T at 0.
- m and C at 0.
- lsu_ren=0, lsu_wen=0, lsu_wdata=0, lsu_addr_offset=0.
- done=0 and result=0.
REQ-029 No partial result SHALL be written after reset; the first start following reset SHALL begin a fresh operation.

Configuration
REQ-030 Macro MONT_MUL_FINAL_SUB_EN, when defined, SHALL include CLEANUP, and result SHALL lie in [0, N).
REQ-031 When MONT_MUL_FINAL_SUB_EN is undefined:
- CLEANUP and its subtractor are removed.
- RED goes directly to WRITE.
- result lies in [0, 2N) and is congruent mod N.
- Latency is one cycle shorter.

Verification
REQ-032 The bench SHALL cover these scenarios with WORDS=4 and an LSU model returning lsu_done one cycle after each request:
- Identity: A = R mod N, B = 5, N = 13, n0_inv = -13^-1 mod 2^32, sqr=0 -> result = 5; 12 reads and 4 writes; done pulses once.
- Square mode: A = R mod 13, sqr=1, same N and n0_inv -> only 8 reads with no op_address_sel=1 read; result = R mod 13.
- Zero operand: A = 0, B = random, N = 2^127+1 -> result = 0; compute phase exactly 36 cycles.
- Final subtraction: operands chosen so that the pre-CLEANUP T lies in [N, 2N) -> result = T - N with the macro defined, and result = T with it undefined.
- Reset mid-RED: rst_n=0 for one cycle during RED of i=2 -> next cycle IDLE, lsu_ren=0, lsu_wen=0, result=0, no writes issued; a following start produces the correct result.
- Busy start: start pulsed during MUL_AB -> no restart and an unchanged result, with exactly one done pulse.

Source files
------------

// File: rtl/mont_mul_cios.sv
// mont_mul_cios: word-serial CIOS Montgomery multiplier, M = A*B*R^-1 mod N with R = 2^(32*WORDS)
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   start, sqr, n0_inv      operation request; square mode and -N^-1 mod 2^32 sampled with start
//   lsu_ren/lsu_wen         LSU read/write request, lsu_type fixed DATA_WORD
//   lsu_addr_offset         byte offset of current word (word_index*4)
//   lsu_done, lsu_rdata     LSU access completion and read data; lsu_wdata write data
//   op_address_sel          base select 0=A 1=B 2=N 3=result
//   result, done            final M (held until the next completion) and one-cycle completion pulse
// Build option: define MONT_MUL_FINAL_SUB_EN to add the CLEANUP final subtraction (result in [0,N));
// without it the result lies in [0,2N).
module mont_mul_cios #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sqr,
  input  logic [31:0]         n0_inv,
  output logic                lsu_ren,
  output logic                lsu_wen,
  output logic [1:0]          lsu_type,
  output logic [31:0]         lsu_addr_offset,
  input  logic                lsu_done,
  input  logic [31:0]         lsu_rdata,
  output logic [31:0]         lsu_wdata,
  output logic [1:0]          op_address_sel,
  output logic [32*WORDS-1:0] result,
  output logic                done
);
  localparam int BITS = 32 * WORDS;
  localparam int CW = $clog2(WORDS);
  localparam logic [1:0] DATA_WORD = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);
  typedef enum logic [2:0] {IDLE, PREPARE, FETCH, MUL_AB, CALC_M, RED, CLEANUP, WRITE} state_t;
`ifdef MONT_MUL_FINAL_SUB_EN
  localparam state_t POST_RED = CLEANUP;
`else
  localparam state_t POST_RED = WRITE;
`endif
  state_t state, nxt;
  logic [CW-1:0] i, j, jm1;
  logic [1:0] phase;
  logic [31:0] a [WORDS];
  logic [31:0] b [WORDS];
  logic [31:0] n [WORDS];
  logic [31:0] t [WORDS];
  logic [31:0] t_w, t_w1, m, c, n0, bi, mul_x, mul_y, offs;
  logic sqr_r, last_j, last_i;
  logic [63:0] acc, mac;
  logic [32:0] red_top;
  logic [BITS-1:0] t_flat;
  assign lsu_type = DATA_WORD;
  assign last_j = j == LAST;
  assign last_i = i == LAST;
  assign jm1 = j - 1'b1;
  assign offs = {{(30 - CW){1'b0}}, j, 2'b00};
  assign bi = sqr_r ? a[i] : b[i];
  // One shared 32x32+32+32 MAC: A[j]*B[i] in MUL_AB, m*N[j] in RED, T[0]*n0_inv in CALC_M
  assign mul_x = state == MUL_AB ? a[j] : state == RED ? m : t[0];
  assign mul_y = state == MUL_AB ? bi : state == RED ? n[j] : n0;
  assign acc = (state == MUL_AB || state == RED) ? {32'b0, t[j]} + {32'b0, c} : 64'b0;
  assign mac = {32'b0, mul_x} * {32'b0, mul_y} + acc;
  assign red_top = {1'b0, t_w} + {1'b0, mac[63:32]};
  always_comb begin
    t_flat = '0;
    for (int k = 0; k < WORDS; k++) t_flat[32*k +: 32] = t[k];
  end
`ifdef MONT_MUL_FINAL_SUB_EN
  logic [BITS-1:0] n_flat;
  logic [BITS+64:0] diff;
  always_comb begin
    n_flat = '0;
    for (int k = 0; k < WORDS; k++) n_flat[32*k +: 32] = n[k];
  end
  // Top bit is the borrow: clear means T >= N (this includes T[W] != 0)
  assign diff = {1'b0, t_w1, t_w, t_flat} - {65'b0, n_flat};
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    lsu_ren = 1'b0;
    lsu_wen = 1'b0;
    op_address_sel = 2'd0;
    lsu_addr_offset = 32'd0;
    lsu_wdata = 32'd0;
    case (state)
      IDLE: nxt = (start && !done) ? PREPARE : IDLE;
      PREPARE: nxt = FETCH;
      FETCH: begin
        lsu_ren = 1'b1;
        op_address_sel = phase;
        lsu_addr_offset = offs;
        nxt = (lsu_done && last_j && phase == 2'd2) ? MUL_AB : FETCH;
      end
      MUL_AB: nxt = last_j ? CALC_M : MUL_AB;
      CALC_M: nxt = RED;
      RED: nxt = !last_j ? RED : !last_i ? MUL_AB : POST_RED;
`ifdef MONT_MUL_FINAL_SUB_EN
      CLEANUP: nxt = WRITE;
`endif
      WRITE: begin
        lsu_wen = 1'b1;
        op_address_sel = 2'd3;
        lsu_addr_offset = offs;
        lsu_wdata = t[j];
        nxt = (lsu_done && last_j) ? IDLE : WRITE;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < WORDS; k++) begin
        a[k] <= '0;
        b[k] <= '0;
        n[k] <= '0;
        t[k] <= '0;
      end
      t_w <= '0;
      t_w1 <= '0;
      m <= '0;
      c <= '0;
      n0 <= '0;
      sqr_r <= 1'b0;
      i <= '0;
      j <= '0;
      phase <= '0;
      result <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && !done) begin
          sqr_r <= sqr;
          n0 <= n0_inv;
        end
        PREPARE: begin
          for (int k = 0; k < WORDS; k++) t[k] <= '0;
          t_w <= '0;
          t_w1 <= '0;
          m <= '0;
          c <= '0;
          i <= '0;
          j <= '0;
          phase <= '0;
        end
        FETCH: if (lsu_done) begin
          if (phase == 2'd0) a[j] <= lsu_rdata;
          else if (phase == 2'd1) b[j] <= lsu_rdata;
          else n[j] <= lsu_rdata;
          j <= last_j ? '0 : j + 1'b1;
          if (last_j) phase <= (phase == 2'd0 && !sqr_r) ? 2'd1 : 2'd2;
        end
        MUL_AB: begin
          t[j] <= mac[31:0];
          if (last_j) begin
            {t_w1, t_w} <= {t_w1, t_w} + {32'b0, mac[63:32]};
            c <= '0;
            j <= '0;
          end else begin
            c <= mac[63:32];
            j <= j + 1'b1;
          end
        end
        CALC_M: m <= mac[31:0];
        RED: begin
          // Word 0 of the sum is zero by choice of m; the rest shift down one word
          if (j != '0) t[jm1] <= mac[31:0];
          if (last_j) begin
            t[LAST] <= red_top[31:0];
            t_w <= t_w1 + {31'b0, red_top[32]};
            t_w1 <= '0;
            c <= '0;
            j <= '0;
            i <= last_i ? '0 : i + 1'b1;
          end else begin
            c <= mac[63:32];
            j <= j + 1'b1;
          end
        end
`ifdef MONT_MUL_FINAL_SUB_EN
        CLEANUP: if (!diff[BITS+64]) begin
          for (int k = 0; k < WORDS; k++) t[k] <= diff[32*k +: 32];
          t_w <= diff[BITS +: 32];
          t_w1 <= diff[BITS+32 +: 32];
        end
`endif
        WRITE: if (lsu_done) begin
          if (last_j) begin
            j <= '0;
            done <= 1'b1;
            result <= t_flat;
          end else j <= j + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mont_mul_cios.sv
// tb_mont_mul_cios: directed-vector bench for mont_mul_cios with WORDS=4 and a one-cycle LSU model
module tb_mont_mul_cios;
  localparam logic [127:0] N13 = 128'd13;
  localparam logic [31:0] NINV13 = 32'h3B13B13B;
  localparam logic [127:0] N_BIG = 128'h80000000_00000000_00000000_00000001;
  localparam logic [31:0] NINV_BIG = 32'hFFFFFFFF;
  localparam logic [127:0] A_FS = 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE;
`ifdef MONT_MUL_FINAL_SUB_EN
  localparam logic [127:0] FS_EXP = 128'h3FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFC;
  localparam int GAP = 37;
`else
  localparam logic [127:0] FS_EXP = 128'hBFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFD;
  localparam int GAP = 36;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sqr = 1'b0;
  logic [31:0] n0_inv = '0;
  logic lsu_ren, lsu_wen, done;
  logic [1:0] lsu_type, op_address_sel;
  logic [31:0] lsu_addr_offset, lsu_wdata;
  logic lsu_done = 1'b0;
  logic [31:0] lsu_rdata = '0;
  logic [127:0] result;
  logic [127:0] mem_a = '0, mem_b = '0, mem_n = '0, wres = '0;
  int n_vec = 0, n_err = 0;
  int reads = 0, writes = 0, b_reads = 0, dones = 0, gap = 0;
  bit seen_r = 0, seen_w = 0, clr = 0;
  mont_mul_cios #(.WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sqr(sqr), .n0_inv(n0_inv),
    .lsu_ren(lsu_ren), .lsu_wen(lsu_wen), .lsu_type(lsu_type),
    .lsu_addr_offset(lsu_addr_offset), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .lsu_wdata(lsu_wdata), .op_address_sel(op_address_sel), .result(result), .done(done)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] rd_word(input logic [1:0] s, input logic [31:0] off);
    logic [127:0] v;
    v = s == 2'd0 ? mem_a : s == 2'd1 ? mem_b : mem_n;
    return v[32*int'(off[3:2]) +: 32];
  endfunction
  always @(posedge clk) begin
    lsu_done <= (lsu_ren || lsu_wen) && !lsu_done;
    lsu_rdata <= rd_word(op_address_sel, lsu_addr_offset);
  end
  always @(negedge clk) begin
    if (clr) begin
      reads = 0;
      writes = 0;
      b_reads = 0;
      dones = 0;
      gap = 0;
      seen_r = 0;
      seen_w = 0;
      wres = '0;
    end else begin
      if (lsu_ren && lsu_done) begin
        reads++;
        if (op_address_sel == 2'd1) b_reads++;
      end
      if (lsu_wen && lsu_done) begin
        writes++;
        wres[32*int'(lsu_addr_offset[3:2]) +: 32] = lsu_wdata;
      end
      if (done) dones++;
      if (lsu_ren) seen_r = 1;
      else if (seen_r && !lsu_wen && !seen_w) gap++;
      if (lsu_wen) seen_w = 1;
    end
  end
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic launch(input logic [127:0] a, input logic [127:0] b, input logic [127:0] n,
                        input logic [31:0] ninv, input logic sq);
    mem_a = a;
    mem_b = b;
    mem_n = n;
    n0_inv = ninv;
    sqr = sq;
    @(posedge clk); #1;
    clr = 1;
    start = 1;
    @(posedge clk); #1;
    clr = 0;
    start = 0;
  endtask
  task automatic wait_done(input string tag);
    bit ok = 0;
    for (int k = 0; k < 600 && !ok; k++) begin
      @(posedge clk); #1;
      ok = done;
    end
    check({tag, "_timeout"}, 128'(ok), 128'd1);
  endtask
  task automatic wait_fetch_end(input string tag);
    bit ok = 0;
    bit s = 0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(posedge clk); #1;
      if (lsu_ren) s = 1;
      else if (s) ok = 1;
    end
    check({tag, "_fetch_timeout"}, 128'(ok), 128'd1);
  endtask
  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask
  initial begin
    int ren_seen;
    logic [127:0] rnd;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ren", 128'(lsu_ren), 128'd0);
    check("rst_wen", 128'(lsu_wen), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_result", result, 128'd0);
    check("rst_offset", 128'(lsu_addr_offset), 128'd0);
    check("rst_wdata", 128'(lsu_wdata), 128'd0);
    rst_n = 1;
    // identity: A = R mod 13 = 9, B = 5 -> 5
    launch(128'd9, 128'd5, N13, NINV13, 1'b0);
    wait_done("id");
    check("id_result", result, 128'd5);
    check("id_wdata", wres, 128'd5);
    check("id_reads", 128'(reads), 128'd12);
    check("id_writes", 128'(writes), 128'd4);
    check("id_b_reads", 128'(b_reads), 128'd4);
    check("id_gap", 128'(gap), 128'(GAP));
    settle();
    check("id_dones", 128'(dones), 128'd1);
    // square: B memory holds a decoy that must never be read
    launch(128'd9, 128'd7, N13, NINV13, 1'b1);
    wait_done("sq");
    check("sq_result", result, 128'd9);
    check("sq_reads", 128'(reads), 128'd8);
    check("sq_b_reads", 128'(b_reads), 128'd0);
    settle();
    check("sq_dones", 128'(dones), 128'd1);
    // zero operand, plus a start held during the done pulse
    rnd = {$urandom, $urandom, $urandom, $urandom};
    rnd[127] = 1'b0;
    launch(128'd0, rnd, N_BIG, NINV_BIG, 1'b0);
    wait_done("zero");
    start = 1;
    @(posedge clk); #1;
    start = 0;
    ren_seen = 0;
    repeat (4) begin
      if (lsu_ren) ren_seen++;
      @(posedge clk); #1;
    end
    check("zero_result", result, 128'd0);
    check("zero_gap", 128'(gap), 128'(GAP));
    check("start_on_done_ren", 128'(ren_seen), 128'd0);
    check("zero_dones", 128'(dones), 128'd1);
    // pre-CLEANUP T = 3*2^126-3 lies in [N, 2N)
    launch(A_FS, A_FS, N_BIG, NINV_BIG, 1'b0);
    wait_done("fs");
    check("fs_result", result, FS_EXP);
    check("fs_wdata", wres, FS_EXP);
    // reset during RED of i=2: MUL_AB entry + 24 cycles is RED j=1 of i=2
    launch(128'd9, 128'd5, N13, NINV13, 1'b0);
    wait_fetch_end("rst");
    repeat (24) @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk); #1;
    check("midrst_ren", 128'(lsu_ren), 128'd0);
    check("midrst_wen", 128'(lsu_wen), 128'd0);
    check("midrst_result", result, 128'd0);
    check("midrst_done", 128'(done), 128'd0);
    check("midrst_offset", 128'(lsu_addr_offset), 128'd0);
    rst_n = 1;
    repeat (40) @(posedge clk);
    #1;
    check("midrst_writes", 128'(writes), 128'd0);
    check("midrst_dones", 128'(dones), 128'd0);
    launch(128'd9, 128'd5, N13, NINV13, 1'b0);
    wait_done("post_rst");
    check("post_rst_result", result, 128'd5);
    check("post_rst_reads", 128'(reads), 128'd12);
    // start pulsed while busy in MUL_AB must not restart the operation
    launch(128'd9, 128'd7, N13, NINV13, 1'b1);
    wait_fetch_end("busy");
    repeat (2) @(posedge clk);
    #1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    wait_done("busy");
    check("busy_result", result, 128'd9);
    check("busy_reads", 128'(reads), 128'd8);
    check("busy_writes", 128'(writes), 128'd4);
    settle();
    check("busy_dones", 128'(dones), 128'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
